// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, computes the result at acceptance
// and holds it in PHI/PLO until a fixed latency counter expires, modelling the iterative unit.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  localparam int MAX_CYC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CLOG_CYC = $clog2(MAX_CYC + 1);
  localparam int CNT_W    = (CLOG_CYC < 4) ? 4 : CLOG_CYC;

  localparam logic [CNT_W-1:0] MULT_LD = MULT_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DIV_LD  = DIV_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  md_op_e      op;
  logic        busy;
  logic        accept;

  logic [63:0] mul_a, mul_b, prod;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, dvd, dvs, q_mag, r_mag, quot, rem;

  assign op     = md_op_e'(MDOp);
  assign busy   = (cnt_q != '0);
  assign accept = Start && !Flush && !busy && (op != OP_NONE) && (op != OP_RSVD);

  // Signed product comes from sign-extending both operands; low 64 bits are exact.
  always_comb begin
    mul_a = (op == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
    mul_b = (op == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
    prod  = mul_a * mul_b;
  end

  // Signed divide is done on magnitudes so 0x80000000 / -1 never overflows.
  always_comb begin
    div_signed = (op == OP_DIV);
    a_neg      = A[31];
    b_neg      = B[31];
    a_mag      = a_neg ? (32'd0 - A) : A;
    b_mag      = b_neg ? (32'd0 - B) : B;
    dvd        = div_signed ? a_mag : A;
    dvs        = div_signed ? b_mag : B;
    q_mag      = (dvs == 32'd0) ? 32'd0 : (dvd / dvs);
    r_mag      = (dvs == 32'd0) ? 32'd0 : (dvd % dvs);
    quot       = (div_signed && (a_neg ^ b_neg)) ? (32'd0 - q_mag) : q_mag;
    rem        = (div_signed && a_neg) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if ((cnt_q == CNT_ONE) && !dz_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (accept) begin
      unique case (op)
        OP_MULT, OP_MULTU: begin
          phi_d = prod[63:32];
          plo_d = prod[31:0];
          cnt_d = MULT_LD;
          dz_d  = 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          phi_d = rem;
          plo_d = quot;
          cnt_d = DIV_LD;
          dz_d  = (B == 32'd0);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

  assign Busy = busy;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed test-plan steps followed by random commands,
// checked against 64-bit arithmetic reference results.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Flush;
  logic        Busy;
  logic [31:0] HI, LO;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDOp (MDOp),
    .A    (A),
    .B    (B),
    .Flush(Flush),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, b,
                                             input logic [31:0] hi, lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int ref_cycles(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge. Optionally pokes a Start while busy.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit fl, input int poke_at, input bit poke_fl);
    logic [63:0] r;
    int          n;
    int          en;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    if (fl) begin
      r  = {m_hi, m_lo};
      en = 0;
    end else begin
      r  = ref_result(op, a, b, m_hi, m_lo);
      en = ref_cycles(op);
    end
    Start = 1'b1; MDOp = op; A = a; B = b; Flush = fl;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7));
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      check("hold_hi", HI, old_hi);
      check("hold_lo", LO, old_lo);
      if (n == poke_at) begin
        Start = 1'b1; MDOp = 3'd3; Flush = poke_fl;
      end else begin
        Start = 1'b0; Flush = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    Start = 1'b0; Flush = 1'b0;
    check("busy_len", n, en);
    check("hi", HI, r[63:32]);
    check("lo", LO, r[31:0]);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; Start = 1'b0; Flush = 1'b0; MDOp = 3'd0; A = '0; B = '0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0, -1, 1'b0);
    check("mult_hi_c", HI, 32'hFFFFFFFF);
    check("mult_lo_c", LO, 32'hFFFFFFFE);
    run_cmd(3'd2, 32'hFFFFFFFF, 32'h2, 1'b0, -1, 1'b0);
    check("multu_hi_c", HI, 32'h00000001);
    check("multu_lo_c", LO, 32'hFFFFFFFE);
    run_cmd(3'd3, 32'hFFFFFFF9, 32'h2, 1'b0, -1, 1'b0);
    check("div_lo_c", LO, 32'hFFFFFFFD);
    check("div_hi_c", HI, 32'hFFFFFFFF);
    run_cmd(3'd4, 32'd7, 32'd2, 1'b0, -1, 1'b0);
    check("divu_lo_c", LO, 32'd3);
    check("divu_hi_c", HI, 32'd1);
    run_cmd(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 1'b0);
    check("ovf_lo_c", LO, 32'h80000000);
    check("ovf_hi_c", HI, 32'h00000000);

    run_cmd(3'd5, 32'h12345678, $urandom, 1'b0, -1, 1'b0);
    run_cmd(3'd6, 32'h9ABCDEF0, $urandom, 1'b0, -1, 1'b0);
    run_cmd(3'd4, $urandom, 32'd0, 1'b0, -1, 1'b0);
    check("dz_hi_c", HI, 32'h12345678);
    check("dz_lo_c", LO, 32'h9ABCDEF0);

    // Div presented on the second busy cycle of a mult, then a flushed mult at commit.
    run_cmd(3'd1, $urandom, $urandom, 1'b0, 1, 1'b0);
    run_cmd(3'd1, $urandom, $urandom, 1'b1, -1, 1'b0);
    run_cmd(3'd2, $urandom, $urandom, 1'b1, -1, 1'b0);
    run_cmd(3'd3, $urandom, $urandom_range(1, 1000), 1'b0, 3, 1'b1);

    run_cmd(3'd5, 32'hCAFEF00D, 32'd0, 1'b0, -1, 1'b0);
    run_cmd(3'd6, 32'h0BADBEEF, 32'd0, 1'b0, -1, 1'b0);
    Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7; Flush = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_cmd(3'd2, $urandom, $urandom, 1'b0, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_cmd(op, a, b, ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the P7 pipelined MIPS core. It sits in the EX stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo commands with operands from the forwarding muxes, holds the HI/LO architectural registers, and drives Busy to the hazard unit for mfhi/mflo/md stalls. HI and LO feed the EX result-select mux alongside the ALU result.

## Interface
- MULT_CYCLES, default 5: Busy duration of mult/multu, in cycles (≥1).
- DIV_CYCLES, default 10: Busy duration of div/divu, in cycles (≥1).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Start  input  1  command valid this cycle (EX-stage instruction is an MD op).
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  rs operand (forwarded); dividend / multiplicand / mthi-mtlo source.
- B  input  32  rt operand (forwarded); divisor / multiplier.
- Flush  input  1  exception/interrupt taken this cycle; suppresses the current command.
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

## Operation
- Internal state: HI, LO, a pending pair PHI/PLO, and a down-counter cnt (4 bits minimum; sized to max(MULT_CYCLES, DIV_CYCLES)). Busy = (cnt != 0), registered only.
- Command accepted at an edge iff Start=1, Flush=0, Busy=0, MDOp in 1..6. Otherwise the edge changes nothing except the counter/commit below.
- mult: {PHI,PLO} = signed(A)*signed(B), 64-bit; cnt loads MULT_CYCLES.
- multu: {PHI,PLO} = unsigned product; cnt loads MULT_CYCLES.
- div: PLO = quotient truncated toward zero; PHI = remainder with the sign of the dividend; cnt loads DIV_CYCLES.
- divu: unsigned quotient/remainder; cnt loads DIV_CYCLES.
- Divide by B=0: cnt still loads DIV_CYCLES; at commit, HI/LO are left unchanged.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- mthi: HI <= A at the accepting edge. mtlo: LO <= A at the accepting edge. cnt stays 0; no Busy.
- Each edge with cnt != 0: cnt <= cnt-1. On the 1->0 transition, HI <= PHI and LO <= PLO (unless the operation was a divide by zero).
- Start while Busy: ignored. The hazard unit stalls on (Start & Busy), so the unit never needs to queue.
- Flush while Busy: in-flight operation continues and commits normally. Only the command presented in the Flush cycle is dropped.
- Operands are captured at acceptance. A/B changes after acceptance have no effect.
- reset: cnt=0, Busy=0, HI=0, LO=0, PHI=0, PLO=0, asynchronously, including mid-operation. The in-flight result is lost.

## Timing
- Accept at edge t: Busy=1 from just after t through edge t+N, where N = MULT_CYCLES or DIV_CYCLES. Busy=0 and the new HI/LO are visible in the same cycle, just after edge t+N.
- Back-to-back: a new command is accepted at edge t+N+1 at earliest, which is the first cycle Busy=0.
- mthi/mtlo: HI/LO are visible one cycle after the accepting edge. A following mfhi reads the new value with no stall.
- HI/LO are direct register outputs with no combinational path from inputs. Busy has no combinational path from Start.
- Reset values of all outputs: Busy=0, HI=0x00000000, LO=0x00000000.

## Test plan
- reset, then mult A=0xFFFFFFFF B=0x00000002 -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; repeat with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7) B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3, HI=1; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678, next cycle mtlo A=0x9ABCDEF0 -> HI/LO update one edge each, Busy never asserts; then divu B=0 -> Busy 10 cycles, HI/LO unchanged.
- During a mult (cycle 2 of 5), present Start div with Flush=0 -> ignored, mult result commits on schedule; at the commit cycle, present Start with Flush=1 -> not accepted, Busy stays 0.
- Start mult with Flush=1 while idle -> no Busy, HI/LO unchanged; Flush=1 during an in-flight div -> div completes and commits.
- Assert reset asynchronously mid-cycle on cycle 3 of a div -> Busy, HI, LO go to 0 immediately without a clock edge; after release, first command behaves normally.
